// File: rtl/trigger_manager.sv
// Trigger manager: synchronised ext/sw requests, arm/fire/holdoff FSM, counters.
// Optional TRIGGER_MANAGER_LOST_CNT_EN adds the saturating lost-request counter.
module trigger_manager #(
  parameter int HOLDOFF_W = 16,
  parameter int CNT_W     = 24
) (
  input  logic                 ipb_clk,
  input  logic                 ipb_rst_n,
  input  logic                 ext_trig,
  input  logic                 sw_trig,
  input  logic                 trig_enable,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  input  logic [4:0]           chan_busy,
  output logic                 trigger_out,
  output logic [CNT_W-1:0]     trig_count,
  output logic [15:0]          lost_count,
  output logic [1:0]           state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [HOLDOFF_W-1:0] hcnt, hcnt_nxt;
  logic                 sync1, sync2, sync_q;
  logic                 req, fire;

  // sync_q holds the previous synchronised level for edge detection
  always_ff @(posedge ipb_clk or negedge ipb_rst_n) begin
    if (!ipb_rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync1  <= ext_trig;
      sync2  <= sync1;
      sync_q <= sync2;
    end
  end

  assign req = (sync2 & ~sync_q) | sw_trig;

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        hcnt_nxt = '0;
        if (trig_enable) state_nxt = ARMED;
      end
      ARMED: begin
        if (!trig_enable) begin
          state_nxt = IDLE;
        end else if (req && chan_busy == 5'd0) begin
          state_nxt = FIRE;
          fire      = 1'b1;
        end
      end
      FIRE: begin
        if (!trig_enable) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
        end else if (holdoff_cycles != '0) begin
          state_nxt = HOLDOFF;
          hcnt_nxt  = holdoff_cycles;
        end else begin
          state_nxt = ARMED;
        end
      end
      HOLDOFF: begin
        if (!trig_enable) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
        end else if (hcnt <= HOLDOFF_W'(1)) begin
          state_nxt = ARMED;
          hcnt_nxt  = '0;
        end else begin
          hcnt_nxt = hcnt - HOLDOFF_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge ipb_clk or negedge ipb_rst_n) begin
    if (!ipb_rst_n) begin
      state       <= IDLE;
      hcnt        <= '0;
      trigger_out <= 1'b0;
      trig_count  <= '0;
    end else begin
      state       <= state_nxt;
      hcnt        <= hcnt_nxt;
      trigger_out <= fire;
      trig_count  <= trig_count + CNT_W'(fire);
    end
  end

  assign state_out = state;

`ifdef TRIGGER_MANAGER_LOST_CNT_EN
  logic lost;

  assign lost = trig_enable & req &
                ((state == ARMED && chan_busy != 5'd0) ||
                 state == FIRE || state == HOLDOFF);

  always_ff @(posedge ipb_clk or negedge ipb_rst_n) begin
    if (!ipb_rst_n)
      lost_count <= '0;
    else if (lost && lost_count != 16'hFFFF)
      lost_count <= lost_count + 16'd1;
  end
`else
  assign lost_count = '0;
`endif

endmodule

// File: tb/tb_trigger_manager.sv
// Directed bench for trigger_manager; a narrow-counter twin checks wrap.
module tb_trigger_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext, sw, en;
  logic [15:0] hold;
  logic [4:0]  busy;
  logic        tout, tout_w;
  logic [23:0] tcnt;
  logic [3:0]  tcnt_w;
  logic [15:0] lcnt, lcnt_w;
  logic [1:0]  st, st_w;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  always #5 clk = ~clk;

  trigger_manager dut (
    .ipb_clk(clk), .ipb_rst_n(rst_n), .ext_trig(ext),
    .sw_trig(sw), .trig_enable(en), .holdoff_cycles(hold),
    .chan_busy(busy), .trigger_out(tout), .trig_count(tcnt),
    .lost_count(lcnt), .state_out(st)
  );

  trigger_manager #(.CNT_W(4)) dut_w (
    .ipb_clk(clk), .ipb_rst_n(rst_n), .ext_trig(ext),
    .sw_trig(sw), .trig_enable(en), .holdoff_cycles(hold),
    .chan_busy(busy), .trigger_out(tout_w), .trig_count(tcnt_w),
    .lost_count(lcnt_w), .state_out(st_w)
  );

`ifdef TRIGGER_MANAGER_LOST_CNT_EN
  localparam logic [15:0] LOST1 = 16'd1;
`else
  localparam logic [15:0] LOST1 = 16'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] h);
    rst_n = 1'b0; ext = 0; sw = 0; en = 0;
    busy = '0; hold = h;
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ext = 0; sw = 0; en = 0; busy = '0; hold = '0;
    tick();
    chk("rst_state", 32'(st), 0);
    chk("rst_out", 32'(tout), 0);
    chk("rst_tcnt", 32'(tcnt), 0);
    chk("rst_lcnt", 32'(lcnt), 0);

    // ext held high for 10+ cycles -> single pulse at E0+2
    do_reset(16'd4);
    chk("armed", 32'(st), 1);
    ext = 1'b1;
    tick();
    chk("ext_e0", 32'(tout), 0);
    tick();
    chk("ext_e1", 32'(tout), 0);
    tick();
    chk("ext_e2", 32'(tout), 1);
    chk("ext_fire_st", 32'(st), 2);
    tick();
    chk("ext_hold_st", 32'(st), 3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (tout) pulses++;
      tick();
    end
    ext = 1'b0;
    chk("ext_extra", 32'(pulses), 0);
    chk("ext_tcnt", 32'(tcnt), 1);
    chk("ext_lcnt", 32'(lcnt), 0);

    // sw pulses 3 cycles apart, holdoff 4
    do_reset(16'd4);
    sw = 1'b1; tick(); sw = 1'b0;
    chk("sw1_out", 32'(tout), 1);
    tick(); tick();
    sw = 1'b1; tick(); sw = 1'b0;
    chk("sw2_out", 32'(tout), 0);
    chk("sw2_lost", 32'(lcnt), 32'(LOST1));
    tick(); tick();
    chk("sw3_armed", 32'(st), 1);
    sw = 1'b1; tick(); sw = 1'b0;
    chk("sw3_out", 32'(tout), 1);
    chk("sw3_tcnt", 32'(tcnt), 2);

    // busy channel blocks, then clears
    do_reset(16'd4);
    busy = 5'b00100;
    sw = 1'b1; tick(); sw = 1'b0;
    chk("busy_out", 32'(tout), 0);
    chk("busy_st", 32'(st), 1);
    chk("busy_lost", 32'(lcnt), 32'(LOST1));
    busy = '0;
    sw = 1'b1; tick(); sw = 1'b0;
    chk("free_out", 32'(tout), 1);
    chk("free_tcnt", 32'(tcnt), 1);

    // ext edge and sw in the same cycle count once
    do_reset(16'd4);
    ext = 1'b1;
    tick(); tick();
    sw = 1'b1; tick(); sw = 1'b0;
    chk("both_out", 32'(tout), 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tout) pulses++;
    end
    ext = 1'b0;
    chk("both_extra", 32'(pulses), 0);
    chk("both_tcnt", 32'(tcnt), 1);
    chk("both_lcnt", 32'(lcnt), 0);

    // holdoff 0: a pulse every 2 cycles; 4-bit twin wraps
    do_reset(16'd0);
    for (int i = 0; i < 16; i++) begin
      sw = 1'b1; tick(); sw = 1'b0;
      if (i == 0 || i == 15) begin
        chk("h0_out", 32'(tout), 1);
      end
      if (i == 14) chk("wrap_ones", 32'(tcnt_w), 15);
      tick();
      if (i == 0) chk("h0_gap", 32'(tout), 0);
    end
    chk("h0_tcnt", 32'(tcnt), 16);
    chk("wrap_zero", 32'(tcnt_w), 0);

    // reset in HOLDOFF aborts; ext high across release gives one pulse
    do_reset(16'd4);
    sw = 1'b1; tick(); sw = 1'b0;
    tick();
    chk("pre_rst_st", 32'(st), 3);
    ext = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_st", 32'(st), 0);
    chk("arst_tcnt", 32'(tcnt), 0);
    chk("arst_out", 32'(tout), 0);
    chk("arst_lcnt", 32'(lcnt), 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tout) pulses++;
      if (i == 2) chk("rel_e2", 32'(tout), 1);
    end
    chk("rel_pulses", 32'(pulses), 1);
    chk("rel_tcnt", 32'(tcnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
